// File: rtl/sender_ok_ser_pkg.sv
// Shared constants for the response-string sender and its receiver counterpart:
// FSM state codes, string bytes and string lengths.
package sender_ok_ser_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [2:0] MSG_OK_LEN  = 3'd4;
  localparam logic [2:0] MSG_ERR_LEN = 3'd7;

  localparam logic [7:0] MSG_OK  [0:3] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
  localparam logic [7:0] MSG_ERR [0:6] = '{8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, 8'h0D, 8'h0A};

  function automatic logic [2:0] msg_len(input logic sel);
    return sel ? MSG_ERR_LEN : MSG_OK_LEN;
  endfunction

endpackage

// File: rtl/sender_ok_ser_if.sv
// Request/UART-byte handshake bundle between the sender and its environment.
interface sender_ok_ser_if;
  logic       send_req;
  logic       msg_sel;
  logic       SEND_END;
  logic [7:0] txd;
  logic       SEND_START;
  logic       busy;
  logic       send_done;
  logic       send_err;

  modport master (
    output send_req, msg_sel, SEND_END,
    input  txd, SEND_START, busy, send_done, send_err
  );

  modport slave (
    input  send_req, msg_sel, SEND_END,
    output txd, SEND_START, busy, send_done, send_err
  );
endinterface

// File: rtl/sender_ok_ser_tx_msg_rom.sv
// Combinational string ROM: byte at (sel, index) and the selected string length.
module tx_msg_rom
  import sender_ok_ser_pkg::*;
(
  input  logic       sel_i,
  input  logic [2:0] index_i,
  output logic [7:0] byte_o,
  output logic [2:0] len_o
);

  always_comb begin
    len_o  = msg_len(sel_i);
    byte_o = 8'h00;
    if (index_i < len_o) begin
      byte_o = sel_i ? MSG_ERR[index_i] : MSG_OK[index_i[1:0]];
    end
  end

endmodule

// File: rtl/sender_ok_ser.sv
// Sends "OK\r\n" or "ERROR\r\n" one byte at a time through a UART byte transmitter,
// with a per-byte timeout.
//
// state | meaning
// IDLE  | waiting for send_req
// LOAD  | register txd from ROM
// START | SEND_START pulse high
// WAIT  | waiting for SEND_END, timeout counter running
// DONE  | send_done pulse high
module sender_ok_ser
  import sender_ok_ser_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic           iCLK,
  input  logic           RST_n,
  sender_ok_ser_if.slave bus
);

  state_e      state_q;
  logic        sel_q;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  txd_q;
  logic        send_start_q, busy_q, send_done_q, send_err_q;

  logic [7:0]  rom_byte;
  logic [2:0]  rom_len;
  logic        last_byte;
  logic        expired;

  tx_msg_rom u_rom (
    .sel_i   (sel_q),
    .index_i (idx_q),
    .byte_o  (rom_byte),
    .len_o   (rom_len)
  );

  assign last_byte = (idx_q == rom_len - 3'd1);
  assign idx_d     = last_byte ? idx_q : idx_q + 3'd1;
  assign cnt_d     = cnt_q + 16'd1;
  // The SEND_START cycle is the first counted cycle of the byte's budget.
  assign expired   = (cnt_q >= TIMEOUT_CYC - 16'd1);

  always_ff @(posedge iCLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      idx_q        <= 3'd0;
      cnt_q        <= 16'd0;
      txd_q        <= 8'h00;
      send_start_q <= 1'b0;
      busy_q       <= 1'b0;
      send_done_q  <= 1'b0;
      send_err_q   <= 1'b0;
    end else begin
      send_start_q <= 1'b0;
      send_done_q  <= 1'b0;
      send_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.send_req) begin
            sel_q   <= bus.msg_sel;
            idx_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          txd_q        <= rom_byte;
          cnt_q        <= 16'd0;
          send_start_q <= 1'b1;
          state_q      <= START;
        end
        START: begin
          cnt_q   <= cnt_d;
          state_q <= WAIT;
        end
        WAIT: begin
          // SEND_END has priority over an expiring timeout.
          if (bus.SEND_END) begin
            if (last_byte) begin
              send_done_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              idx_q   <= idx_d;
              state_q <= LOAD;
            end
          end else if (expired) begin
            send_err_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.txd        = txd_q;
  assign bus.SEND_START = send_start_q;
  assign bus.busy       = busy_q;
  assign bus.send_done  = send_done_q;
  assign bus.send_err   = send_err_q;

endmodule
